// File: rtl/regwrite_arbiter_if.sv
// Bundle of the writeback, late-unit, scoreboard-query and regfile-write
// signals around the register-file write arbiter.
interface regwrite_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_windex;
  logic [31:0]   pipe_win;
  logic          pipe_stall;
  logic          late_valid;
  logic          late_ready;
  logic [4:0]    late_index;
  logic [31:0]   late_data;
  logic          issue_valid;
  logic [4:0]    issue_index;
  logic          flush;
  logic [4:0]    query_a_index;
  logic [4:0]    query_b_index;
  logic          query_a_busy;
  logic          query_b_busy;
  logic [CW-1:0] fifo_count;
  logic          we;
  logic [4:0]    windex;
  logic [31:0]   win;

  // Pipeline / late unit / decode side
  modport master (
    output pipe_we, pipe_windex, pipe_win, late_valid, late_index, late_data,
           issue_valid, issue_index, flush, query_a_index, query_b_index,
    input  pipe_stall, late_ready, query_a_busy, query_b_busy, fifo_count,
           we, windex, win
  );

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_windex, pipe_win, late_valid, late_index, late_data,
           issue_valid, issue_index, flush, query_a_index, query_b_index,
    output pipe_stall, late_ready, query_a_busy, query_b_busy, fifo_count,
           we, windex, win
  );
endinterface

// File: rtl/regwrite_arbiter.sv
// Shares the regfile write port between in-order writeback and an
// out-of-order late unit. Late results wait in a small FIFO; a pending
// scoreboard answers decode hazard queries; a starved FIFO head steals
// the slot by stalling the pipeline.
module regwrite_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  regwrite_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    idx_mem_q [FIFO_DEPTH];
  logic [31:0]   dat_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   pending_q, pending_d;
  logic [31:0]   set_mask, clr_mask;
  logic          nonempty, push, pop, stall;
  logic [4:0]    head_idx;
  logic [31:0]   head_dat;

  assign nonempty = (count_q != '0);
  assign head_idx = idx_mem_q[rd_ptr_q];
  assign head_dat = dat_mem_q[rd_ptr_q];

  // Stall is purely registered state gated by flush, so it never depends on pipe_we.
  assign stall          = !rst && !bus.flush && nonempty && (wait_q == WW'(STARVE_LIMIT));
  assign bus.pipe_stall = stall;
  assign bus.late_ready = !rst && !bus.flush && (count_q < CW'(FIFO_DEPTH));
  assign push           = bus.late_valid && bus.late_ready;
  // Head owns the port when it forces a stall or the pipeline leaves the slot idle.
  assign pop            = !rst && !bus.flush && nonempty && (stall || !bus.pipe_we);

  assign bus.fifo_count   = count_q;
  assign bus.query_a_busy = !rst && pending_q[bus.query_a_index];
  assign bus.query_b_busy = !rst && pending_q[bus.query_b_index];

  // Regfile write port mux; index-0 entries drain without writing.
  always_comb begin
    bus.we     = 1'b0;
    bus.windex = bus.pipe_windex;
    bus.win    = bus.pipe_win;
    if (pop) begin
      bus.windex = head_idx;
      bus.win    = head_dat;
      bus.we     = (head_idx != 5'd0);
    end else if (bus.pipe_we && !rst) begin
      bus.we = (bus.pipe_windex != 5'd0);
    end
  end

  // Next-state for pointers, occupancy, starvation timer and scoreboard.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid && (bus.issue_index != 5'd0))
      set_mask = 32'h1 << bus.issue_index;
    if (pop && (head_idx != 5'd0))
      clr_mask = 32'h1 << head_idx;

    rd_ptr_d  = rd_ptr_q + PW'(pop);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    count_d   = count_q + CW'(push) - CW'(pop);
    pending_d = (pending_q & ~clr_mask) | set_mask;

    if (!nonempty || pop)
      wait_d = '0;
    else if (wait_q != WW'(STARVE_LIMIT))
      wait_d = wait_q + WW'(1);
    else
      wait_d = wait_q;

    if (bus.flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      pending_d = '0;
      wait_d    = '0;
    end
    pending_d[0] = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      pending_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
    end
  end

  // FIFO payload storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem_q[wr_ptr_q] <= bus.late_index;
      dat_mem_q[wr_ptr_q] <= bus.late_data;
    end
  end
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter. Every expected regfile write is queued
// when its stimulus is applied; a monitor pops and compares on each we=1.
module tb_regwrite_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regwrite_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  regwrite_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_w(input logic [4:0] idx, input logic [31:0] data);
    exp_q.push_back({idx, data});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every regfile write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      logic [36:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=%0d:%0h required=none", bus.windex, bus.win);
      end else begin
        e = exp_q.pop_front();
        if ({bus.windex, bus.win} !== e) begin
          bad++;
          $display("FAIL write actual=%0d:%0h required=%0d:%0h",
                   bus.windex, bus.win, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    bus.pipe_we = 0; bus.pipe_windex = 0; bus.pipe_win = 0;
    bus.late_valid = 0; bus.late_index = 0; bus.late_data = 0;
    bus.issue_valid = 0; bus.issue_index = 0; bus.flush = 0;
    bus.query_a_index = 0; bus.query_b_index = 0;

    // Reset state
    smp();
    chk("rst_we", bus.we, 0);
    chk("rst_stall", bus.pipe_stall, 0);
    chk("rst_ready", bus.late_ready, 0);
    chk("rst_busy_a", bus.query_a_busy, 0);
    chk("rst_busy_b", bus.query_b_busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    nxt(); rst = 0;

    // Pipeline-only write
    bus.pipe_we = 1; bus.pipe_windex = 5; bus.pipe_win = 32'hDEADBEEF;
    expect_w(5, 32'hDEADBEEF);
    smp();
    chk("pipe_stall", bus.pipe_stall, 0);
    chk("pipe_ready", bus.late_ready, 1);
    nxt(); bus.pipe_we = 0;

    // Late result into idle slot
    bus.issue_valid = 1; bus.issue_index = 7; bus.query_a_index = 7;
    smp(); chk("late_busy_pre", bus.query_a_busy, 0);
    nxt(); bus.issue_valid = 0;
    bus.late_valid = 1; bus.late_index = 7; bus.late_data = 32'h12345678;
    smp(); chk("late_busy_issued", bus.query_a_busy, 1); chk("late_count_pre", bus.fifo_count, 0);
    nxt(); bus.late_valid = 0; expect_w(7, 32'h12345678);
    smp(); chk("late_count_push", bus.fifo_count, 1); chk("late_we", bus.we, 1);
    chk("late_busy_write", bus.query_a_busy, 1);
    nxt();
    smp(); chk("late_count_after", bus.fifo_count, 0); chk("late_busy_after", bus.query_a_busy, 0);

    // Starvation with pipeline writing every cycle
    nxt();
    bus.late_valid = 1; bus.late_index = 9; bus.late_data = 32'h99;
    bus.pipe_we = 1; bus.pipe_windex = 1; bus.pipe_win = 32'h100;
    expect_w(1, 32'h100);
    smp(); chk("starve_stall0", bus.pipe_stall, 0);
    nxt(); bus.late_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      bus.pipe_win = 32'h100 + k;
      if (k < 5) expect_w(1, 32'h100 + k);
      else       expect_w(9, 32'h99);
      smp();
      chk($sformatf("starve_stall_c%0d", k), bus.pipe_stall, (k == 5) ? 1 : 0);
      chk($sformatf("starve_count_c%0d", k), bus.fifo_count, 1);
      if (k == 5) chk("starve_windex", bus.windex, 9);
      nxt();
    end
    expect_w(1, 32'h105);
    smp(); chk("starve_release", bus.pipe_stall, 0); chk("starve_count_end", bus.fifo_count, 0);
    nxt();

    // FIFO full with pipeline busy; third result is held off
    bus.late_valid = 1;
    for (int q = 0; q <= 4; q++) begin
      bus.pipe_win = 32'h200 + q;
      bus.late_index = (q == 0) ? 5'd10 : (q == 1) ? 5'd11 : 5'd12;
      bus.late_data  = (q == 0) ? 32'hA0 : (q == 1) ? 32'hB0 : 32'hC0;
      expect_w(1, 32'h200 + q);
      smp();
      if (q <= 2) chk($sformatf("full_ready_q%0d", q), bus.late_ready, (q < 2) ? 1 : 0);
      if (q == 2) chk("full_count", bus.fifo_count, 2);
      if (q == 4) chk("full_stall_q4", bus.pipe_stall, 0);
      nxt();
    end
    bus.pipe_win = 32'h205; expect_w(10, 32'hA0);
    smp(); chk("full_stall_q5", bus.pipe_stall, 1); chk("full_ready_q5", bus.late_ready, 0);
    nxt(); expect_w(1, 32'h205);
    smp(); chk("full_stall_q6", bus.pipe_stall, 0); chk("full_ready_q6", bus.late_ready, 1);
    chk("full_count_q6", bus.fifo_count, 1);
    nxt(); bus.late_valid = 0; bus.pipe_we = 0; expect_w(11, 32'hB0);
    smp(); chk("full_count_q7", bus.fifo_count, 2);
    nxt(); expect_w(12, 32'hC0);
    smp(); chk("full_count_q8", bus.fifo_count, 1);
    nxt();
    smp(); chk("full_count_q9", bus.fifo_count, 0);

    // Set wins over clear; index-0 entry discarded
    nxt(); bus.issue_valid = 1; bus.issue_index = 13;
    smp(); nxt();
    bus.issue_index = 3; bus.query_a_index = 13; bus.query_b_index = 3;
    smp(); chk("sim_busy13", bus.query_a_busy, 1);
    nxt(); bus.issue_valid = 0; bus.late_valid = 1; bus.late_index = 3; bus.late_data = 32'h33;
    smp(); chk("sim_busy3", bus.query_b_busy, 1);
    nxt(); bus.late_valid = 0; bus.issue_valid = 1; bus.issue_index = 3; expect_w(3, 32'h33);
    smp(); chk("sim_we", bus.we, 1);
    nxt(); bus.issue_valid = 0;
    smp(); chk("sim_setwins", bus.query_b_busy, 1);
    nxt(); bus.late_valid = 1; bus.late_index = 3; bus.late_data = 32'h34;
    smp(); nxt(); bus.late_valid = 0; expect_w(3, 32'h34);
    smp(); nxt();
    smp(); chk("sim_clear3", bus.query_b_busy, 0);
    nxt(); bus.late_valid = 1; bus.late_index = 0; bus.late_data = 32'hBAD;
    smp(); nxt(); bus.late_valid = 0;
    smp(); chk("zero_we", bus.we, 0); chk("zero_count", bus.fifo_count, 1);
    nxt();
    smp(); chk("zero_count_after", bus.fifo_count, 0); chk("zero_keep13", bus.query_a_busy, 1);

    // Flush with two buffered entries and two pending bits
    nxt(); bus.issue_valid = 1; bus.issue_index = 4;
    bus.query_a_index = 4; bus.query_b_index = 6;
    smp(); nxt();
    bus.issue_index = 6; bus.pipe_we = 1; bus.pipe_windex = 1; bus.pipe_win = 32'h300;
    bus.late_valid = 1; bus.late_index = 4; bus.late_data = 32'h44; expect_w(1, 32'h300);
    smp(); nxt();
    bus.issue_valid = 0; bus.pipe_win = 32'h301; bus.late_index = 6; bus.late_data = 32'h66;
    expect_w(1, 32'h301);
    smp(); chk("fl_busy4_pre", bus.query_a_busy, 1); chk("fl_busy6_pre", bus.query_b_busy, 1);
    nxt(); bus.late_valid = 0; bus.flush = 1; bus.pipe_windex = 2; bus.pipe_win = 32'h22;
    bus.issue_valid = 1; bus.issue_index = 9; expect_w(2, 32'h22);
    smp(); chk("fl_count_pre", bus.fifo_count, 2); chk("fl_ready", bus.late_ready, 0);
    chk("fl_stall", bus.pipe_stall, 0);
    nxt(); bus.flush = 0; bus.pipe_we = 0; bus.issue_valid = 0;
    smp(); chk("fl_count", bus.fifo_count, 0); chk("fl_busy4", bus.query_a_busy, 0);
    chk("fl_busy6", bus.query_b_busy, 0); chk("fl_ready_after", bus.late_ready, 1);
    chk("fl_we", bus.we, 0);
    bus.query_a_index = 9; #1; chk("fl_issue_ignored", bus.query_a_busy, 0);

    // Async reset mid-stream discards buffered result
    nxt(); bus.pipe_we = 1; bus.pipe_windex = 1; bus.pipe_win = 32'h400;
    bus.late_valid = 1; bus.late_index = 15; bus.late_data = 32'hF0; expect_w(1, 32'h400);
    smp(); nxt();
    bus.late_valid = 0; bus.pipe_windex = 8; bus.pipe_win = 32'h401; rst = 1;
    smp(); chk("arst_we", bus.we, 0); chk("arst_count", bus.fifo_count, 0);
    chk("arst_ready", bus.late_ready, 0); chk("arst_stall", bus.pipe_stall, 0);
    nxt(); rst = 0; bus.pipe_we = 0;
    smp(); chk("arst_we_after", bus.we, 0); chk("arst_count_after", bus.fifo_count, 0);
    nxt();
    smp(); chk("arst_we_after2", bus.we, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares the single register-file write port between in-order pipeline writeback and a multi-cycle late unit (mul/div) that returns results out of order.
- Buffers late results in a small FIFO and keeps a 32-entry pending-destination scoreboard for decode hazard checks.
- Forces a writeback slot when late results have been starved too long.
- Sits between the writeback stage, the late unit and the regfile write port.

Parameters:
- FIFO_DEPTH, 2, late-result buffer entries; power of two, minimum 2.
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before the pipeline is stalled; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pipe_we  in  1  writeback stage write request.
- pipe_windex  in  5  writeback destination.
- pipe_win  in  32  writeback data.
- pipe_stall  out  1  writeback slot taken this cycle; pipeline freezes and re-presents its write next cycle.
- late_valid  in  1  late unit result valid.
- late_ready  out  1  FIFO can accept a result.
- late_index  in  5  late result destination.
- late_data  in  32  late result data.
- issue_valid  in  1  multi-cycle op issued this cycle.
- issue_index  in  5  its destination.
- flush  in  1  synchronous kill of all late work.
- query_a_index  in  5  decode source A.
- query_b_index  in  5  decode source B.
- query_a_busy  out  1  source A pending.
- query_b_busy  out  1  source B pending.
- fifo_count  out  log2(FIFO_DEPTH)+1  buffered entries.
- we  out  1  regfile write enable.
- windex  out  5  regfile write index.
- win  out  32  regfile write data.

Behaviour:
- Reset: asynchronous. FIFO pointers, count, pending[31:0] and wait_cnt all clear to 0. While rst is high: we=0, pipe_stall=0, late_ready=0, both busy outputs 0.
- late_ready is 1 when rst=0, flush=0 and count < FIFO_DEPTH. It uses the registered count, so it has no dependency on a same-cycle pop.
- Push on late_valid && late_ready. Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Grant, evaluated each cycle:
  - If pipe_stall=1: the FIFO head owns the port.
  - Else if pipe_we=1: the pipeline owns the port. Outputs are we=1 when pipe_windex!=0, windex=pipe_windex, win=pipe_win.
  - Else if the FIFO is non-empty: the head owns the port.
  - Else: we=0.
- FIFO head owning the port: the head pops, and we=1 when head_index!=0. An entry with index 0 is popped and discarded with we=0.
- wait_cnt:
  - Increments each cycle the FIFO is non-empty and not popped. Saturates at STARVE_LIMIT.
  - Returns to 0 on pop, when the FIFO is empty, or on flush.
- pipe_stall = (wait_cnt == STARVE_LIMIT) && FIFO non-empty && !flush. The signal is combinational from registers.
- Scoreboard:
  - issue_valid with issue_index!=0 sets that pending bit at the clock edge.
  - The bit clears at the edge of the cycle in which a late entry with that index is written.
  - Set and clear of the same index in the same cycle: set wins.
  - Bit 0 is constant 0.
- Busy outputs: query_x_busy = pending[query_x_index]. They read the registers, so busy drops the cycle after the regfile write. This requires the regfile to return the written value on the next cycle.
- Issue-side guarantees, which the arbiter does not check:
  - No issue to an index that is already pending.
  - No pipeline write to a pending index. This rules out a late write-after-write (WAW) overwrite.
- Flush:
  - Clears the FIFO, pending and wait_cnt at the edge.
  - In the flush cycle, late_ready=0, issue is ignored and no FIFO pop occurs.
  - The pipeline write proceeds normally.
- Reset mid-operation discards buffered results without writing them.

Test Plan:
- Pipeline-only path: pipe_we=1, index 5, data 0xDEADBEEF, FIFO empty -> same cycle we=1, windex=5, win=0xDEADBEEF, pipe_stall=0.
- Late result into an idle slot: issue index 7, then the late unit delivers index 7, data 0x12345678; query_a_index=7 throughout.
  - query_a_busy=1 from the cycle after issue.
  - The push sets fifo_count=1.
  - With pipe_we=0 next cycle: we=1, windex=7, count 0.
  - query_a_busy=0 the following cycle.
- Starvation: STARVE_LIMIT=4, FIFO holds index 9, pipe_we held at 1.
  - wait_cnt counts 1,2,3,4.
  - In the 5th cycle after the push, pipe_stall=1, windex=9 and the FIFO pops.
  - Next cycle pipe_stall=0 and the pipeline write goes out.
- FIFO full: two pushes with DEPTH=2 and pipe_we=1 -> late_ready=0 and late_valid is held off. After one forced pop, late_ready=1.
- Simultaneous events:
  - Issue of index 3 in the same cycle index 3 commits from the FIFO -> pending[3]=1 afterwards.
  - Late index 0 -> popped with we=0 and no scoreboard change.
- Flush: FIFO holds 2 entries, pending={4,6}, flush=1 with pipe_we=1 for index 2.
  - The index 2 write occurs.
  - Next cycle fifo_count=0, both busy=0, late_ready=1.
  - An async rst pulse mid-stream yields we=0 immediately.
